// File: rtl/seq_pkg.sv
// ============================================================================
// Module : seq_pkg
// Brief  : Shared state encoding and default sizing for the program sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam int c_def_pc_w    = 10;
    localparam int c_def_off_w   = 8;
    localparam int c_def_num_pgm = 4;

    // Entry 0 sits in the least-significant slice.
    localparam logic [c_def_num_pgm-1:0][c_def_pc_w-1:0] c_def_pgm_base =
        {10'd384, 10'd256, 10'd128, 10'd0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/prog_sequencer_next_pc.sv
// ============================================================================
// Module : next_pc
// Brief  : Combinational next-PC: hold on stall, relative branch, else +1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module next_pc
    import seq_pkg::*;
#(
    parameter int PC_W  = c_def_pc_w,
    parameter int OFF_W = c_def_off_w
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             stall,
    input  logic             br_en,
    input  logic             br_ne,
    input  logic             zero,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  pc_nxt
);

    logic [PC_W-1:0] w_off_ext;
    logic            w_take;

    // Signed size cast sign-extends; the add then wraps modulo 2**PC_W.
    assign w_off_ext = PC_W'($signed(offset));
    assign w_take    = br_en & (zero ^ br_ne);

    always_comb begin
        pc_nxt = pc + PC_W'(1);
        if (stall) begin
            pc_nxt = pc;
        end else if (w_take) begin
            pc_nxt = pc + w_off_ext;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_sequencer.sv
// ============================================================================
// Module : prog_sequencer
// Brief  : IDLE/RUN/DONE program sequencer with branch, stall and cycle limit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prog_sequencer
    import seq_pkg::*;
#(
    parameter int                               PC_W     = c_def_pc_w,
    parameter int                               NUM_PGM  = c_def_num_pgm,
    parameter int                               OFF_W    = c_def_off_w,
    parameter int                               CYC_W    = 16,
    parameter logic [CYC_W-1:0]                 MAX_CYC  = '1,
    parameter logic [NUM_PGM-1:0][PC_W-1:0]     PGM_BASE = c_def_pgm_base,
    localparam int                              PSEL_W   = (NUM_PGM > 1) ? $clog2(NUM_PGM) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PSEL_W-1:0] PgmSel,
    input  logic              Stall,
    input  logic              BrEn,
    input  logic              BrNe,
    input  logic              Zero,
    input  logic [OFF_W-1:0]  Offset,
    input  logic              HaltReq,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Busy,
    output logic              Ack,
    output logic              Timeout,
    output logic [CYC_W-1:0]  CycleCt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_pc_step;
    logic [PC_W-1:0]  w_base;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    // Out-of-range program indices fall back to entry 0.
    always_comb begin
        w_base = PGM_BASE[0];
        if (int'(PgmSel) < NUM_PGM) begin
            w_base = PGM_BASE[PgmSel];
        end
    end

    next_pc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next_pc (
        .pc     (r_pc),
        .stall  (Stall),
        .br_en  (BrEn),
        .br_ne  (BrNe),
        .zero   (Zero),
        .offset (Offset),
        .pc_nxt (w_pc_step)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_cyc     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cyc     <= w_cyc_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cyc_nxt     = r_cyc;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    w_state_nxt   = ST_RUN;
                    w_pc_nxt      = w_base;
                    w_cyc_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                // Halt outranks the cycle limit; both freeze PC and count.
                if (HaltReq) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b0;
                end else if (r_cyc == MAX_CYC) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_pc_nxt  = w_pc_step;
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ProgCtr = r_pc;
    assign CycleCt = r_cyc;
    assign Timeout = r_timeout;
    assign Busy    = (r_state == ST_RUN);
    assign Ack     = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// ============================================================================
// Module : tb_prog_sequencer
// Brief  : Directed scoreboard bench for three prog_sequencer configurations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_prog_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] psel = 2'd0;
    logic       stall = 1'b0;
    logic       br_en = 1'b0;
    logic       br_ne = 1'b0;
    logic       zero = 1'b0;
    logic [7:0] offset = 8'd0;
    logic       halt = 1'b0;

    logic [9:0]  pc_o   [3];
    logic        busy_o [3];
    logic        ack_o  [3];
    logic        to_o   [3];
    logic [15:0] cc_o   [3];

    always #5 clk = ~clk;

    // Instance 0: all defaults.
    prog_sequencer u_dut (
        .Clk(clk), .Reset(rst), .Start(start), .PgmSel(psel), .Stall(stall),
        .BrEn(br_en), .BrNe(br_ne), .Zero(zero), .Offset(offset), .HaltReq(halt),
        .ProgCtr(pc_o[0]), .Busy(busy_o[0]), .Ack(ack_o[0]), .Timeout(to_o[0]),
        .CycleCt(cc_o[0])
    );

    // Instance 1: short cycle limit.
    prog_sequencer #(.MAX_CYC(16'd10)) u_dut10 (
        .Clk(clk), .Reset(rst), .Start(start), .PgmSel(psel), .Stall(stall),
        .BrEn(br_en), .BrNe(br_ne), .Zero(zero), .Offset(offset), .HaltReq(halt),
        .ProgCtr(pc_o[1]), .Busy(busy_o[1]), .Ack(ack_o[1]), .Timeout(to_o[1]),
        .CycleCt(cc_o[1])
    );

    // Instance 2: three programs, so index 3 is out of range.
    prog_sequencer #(
        .NUM_PGM(3),
        .PGM_BASE({10'd300, 10'd200, 10'd100})
    ) u_dut3 (
        .Clk(clk), .Reset(rst), .Start(start), .PgmSel(psel), .Stall(stall),
        .BrEn(br_en), .BrNe(br_ne), .Zero(zero), .Offset(offset), .HaltReq(halt),
        .ProgCtr(pc_o[2]), .Busy(busy_o[2]), .Ack(ack_o[2]), .Timeout(to_o[2]),
        .CycleCt(cc_o[2])
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [9:0]  pc;
        logic        busy;
        logic        ack;
        logic        to;
        logic [15:0] cc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({pc_o[e.sel], busy_o[e.sel], ack_o[e.sel], to_o[e.sel], cc_o[e.sel]} !==
                {e.pc, e.busy, e.ack, e.to, e.cc}) begin
                errors++;
                $display("FAIL %s dut%0d: got pc=%0d busy=%b ack=%b to=%b cc=%0d, want pc=%0d busy=%b ack=%b to=%b cc=%0d",
                         e.tag, e.sel, pc_o[e.sel], busy_o[e.sel], ack_o[e.sel], to_o[e.sel],
                         cc_o[e.sel], e.pc, e.busy, e.ack, e.to, e.cc);
            end
        end
    end

    task automatic step(input string tag, input int sel,
                        input logic r, input logic s, input logic [1:0] ps,
                        input logic sl, input logic be, input logic bn, input logic z,
                        input logic [7:0] of, input logic h,
                        input logic [9:0] epc, input logic ebusy, input logic eack,
                        input logic eto, input logic [15:0] ecc);
        exp_t e;
        @(negedge clk);
        rst = r; start = s; psel = ps; stall = sl;
        br_en = be; br_ne = bn; zero = z; offset = of; halt = h;
        e.tag = tag; e.sel = sel; e.pc = epc; e.busy = ebusy;
        e.ack = eack; e.to = eto; e.cc = ecc;
        q.push_back(e);
    endtask

    initial begin
        // Launch, increment, stall, branch senses, halt.
        step("reset",        0, 1,0,2'd0, 0,0,0,0,8'h00,0,   10'd0,   0,0,0,16'd0);
        step("idle_hold",    0, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'd0,   0,0,0,16'd0);
        step("launch2",      0, 0,1,2'd2, 0,0,0,0,8'h00,0,   10'd256, 1,0,0,16'd0);
        for (int i = 1; i <= 3; i++)
            step("inc",      0, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'(256+i), 1,0,0,16'(i));
        step("start_in_run", 0, 0,1,2'd0, 0,0,0,0,8'h00,0,   10'd260, 1,0,0,16'd4);
        step("stall",        0, 0,0,2'd0, 1,0,0,0,8'h00,0,   10'd260, 1,0,0,16'd5);
        step("br_to300",     0, 0,0,2'd0, 0,1,0,1,8'd40,0,   10'd300, 1,0,0,16'd6);
        step("br_z1_m4",     0, 0,0,2'd0, 0,1,0,1,8'hFC,0,   10'd296, 1,0,0,16'd7);
        step("br_back",      0, 0,0,2'd0, 0,1,0,1,8'd4, 0,   10'd300, 1,0,0,16'd8);
        step("br_z0_nt",     0, 0,0,2'd0, 0,1,0,0,8'hFC,0,   10'd301, 1,0,0,16'd9);
        step("br_m1",        0, 0,0,2'd0, 0,1,0,1,8'hFF,0,   10'd300, 1,0,0,16'd10);
        step("brne_taken",   0, 0,0,2'd0, 0,1,1,0,8'hFC,0,   10'd296, 1,0,0,16'd11);
        step("brne_nt",      0, 0,0,2'd0, 0,1,1,1,8'hFC,0,   10'd297, 1,0,0,16'd12);
        step("stall_over_br",0, 0,0,2'd0, 1,1,0,1,8'h10,0,   10'd297, 1,0,0,16'd13);
        step("halt_stall",   0, 0,0,2'd0, 1,0,0,0,8'h00,1,   10'd297, 0,1,0,16'd13);
        step("done_hold",    0, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'd297, 0,1,0,16'd13);
        // Wrap-around in both directions.
        step("relaunch0",    0, 0,1,2'd0, 0,0,0,0,8'h00,0,   10'd0,   1,0,0,16'd0);
        step("br_to1023",    0, 0,0,2'd0, 0,1,0,1,8'hFF,0,   10'd1023,1,0,0,16'd1);
        step("inc_wrap",     0, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'd0,   1,0,0,16'd2);
        step("br_p2",        0, 0,0,2'd0, 0,1,0,1,8'd2, 0,   10'd2,   1,0,0,16'd3);
        step("br_m5_wrap",   0, 0,0,2'd0, 0,1,0,1,8'hFB,0,   10'd1021,1,0,0,16'd4);
        // Reset mid-run, reset dominance.
        step("reset_run",    0, 1,0,2'd0, 0,0,0,0,8'h00,0,   10'd0,   0,0,0,16'd0);
        step("launch1",      0, 0,1,2'd1, 0,0,0,0,8'h00,0,   10'd128, 1,0,0,16'd0);
        for (int i = 1; i <= 12; i++)
            step("run_to140", 0, 0,0,2'd0, 0,0,0,0,8'h00,0,  10'(128+i), 1,0,0,16'(i));
        step("reset_mid",    0, 1,1,2'd0, 1,0,0,0,8'h00,1,   10'd0,   0,0,0,16'd0);
        step("reset_start",  0, 1,1,2'd1, 0,0,0,0,8'h00,0,   10'd0,   0,0,0,16'd0);
        step("idle_after",   0, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'd0,   0,0,0,16'd0);

        // Cycle-limit instance.
        step("to_reset",     1, 1,0,2'd0, 0,0,0,0,8'h00,0,   10'd0,   0,0,0,16'd0);
        step("to_launch",    1, 0,1,2'd2, 0,0,0,0,8'h00,0,   10'd256, 1,0,0,16'd0);
        for (int i = 1; i <= 10; i++)
            step("to_run",   1, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'(256+i), 1,0,0,16'(i));
        step("timeout",      1, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'd266, 0,1,1,16'd10);
        step("timeout_hold", 1, 0,0,2'd0, 0,0,0,0,8'h00,0,   10'd266, 0,1,1,16'd10);
        step("to_relaunch",  1, 0,1,2'd1, 0,0,0,0,8'h00,0,   10'd128, 1,0,0,16'd0);

        // Three-program instance: out-of-range select.
        step("p3_reset",     2, 1,0,2'd0, 0,0,0,0,8'h00,0,   10'd0,   0,0,0,16'd0);
        step("p3_sel_oor",   2, 0,1,2'd3, 0,0,0,0,8'h00,0,   10'd100, 1,0,0,16'd0);
        step("p3_halt",      2, 0,0,2'd0, 0,0,0,0,8'h00,1,   10'd100, 0,1,0,16'd0);
        step("p3_sel2",      2, 0,1,2'd2, 0,0,0,0,8'h00,0,   10'd300, 1,0,0,16'd0);

        @(negedge clk);
        rst = 1'b0; start = 1'b0; stall = 1'b0; br_en = 1'b0; halt = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
